instrumented_adder_meter: RTL and testbench
===========================================

# instrumented_adder_meter

Parametrised measurement sequencer for the instrumented-adder family. It selects one of CHANNELS adder instances and one of WIDTH ring bit positions, enables that ring oscillator, waits a settle period, then counts ring rising edges over a programmable clock window. Results are delivered over a valid/ready handshake. A sweep mode steps through every bit position automatically, so one start command characterises a whole adder. It sits between the logic-analyser control registers and the adder instances, replacing per-bit manual ring selection and external counting.

## Interface
- WIDTH, 32: adder width, i.e. the number of selectable ring bit positions (2..64)
- CHANNELS, 4: number of adder instances (1..8)
- COUNT_W, 24: edge-counter and result width
- WINDOW_W, 16: measurement-window width
- SETTLE_CYC, 8: settle cycles between ring enable and counting (1..255)
- wb_clk_i  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command; ignored unless IDLE
- abort  in  1  return to IDLE from any state, no result produced
- sweep  in  1  0 = single bit; 1 = sweep from bit_sel up to WIDTH-1
- chan_sel  in  clog2(CHANNELS) (min 1)  channel; values ≥ CHANNELS are clamped to CHANNELS-1
- bit_sel  in  clog2(WIDTH)  start bit; values ≥ WIDTH are clamped to WIDTH-1
- window  in  WINDOW_W  count-window length in clocks
- ring_in  in  CHANNELS  asynchronous ring-oscillator taps, one per channel
- chan_en  out  CHANNELS  one-hot channel enable
- ring_bit  out  WIDTH  one-hot ring-bit select, driving the adder ring_bit input
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_count  out  COUNT_W  edges counted
- res_chan  out  clog2(CHANNELS)  channel of the result
- res_bit  out  clog2(WIDTH)  bit of the result
- res_ovf  out  1  counter saturated during this measurement

## Operation
- **Latching:** chan_sel, bit_sel, sweep and window are latched when start is accepted. Later changes to these inputs have no effect until the next start.
- **Synchronisation:** ring_in[ch] passes through a 2-flop synchroniser plus a history flop. A rising edge is sync2 & ~hist. Only the latched channel is observed.
- **States:**
  - IDLE: accepting start moves to SETTLE, with bit = clamped bit_sel.
  - SETTLE: chan_en and ring_bit are driven, the counter is held at 0. Lasts exactly SETTLE_CYC cycles, then goes to COUNT.
  - COUNT: counts rising edges for exactly `window` cycles, then goes to REPORT. If window = 0, COUNT is skipped and the count is 0.
  - REPORT: chan_en = 0 and ring_bit = 0; res_valid is high and holds res_* stable until res_ready.
    - On handshake, if sweep and bit < WIDTH-1: increment bit and go to SETTLE.
    - Otherwise go to IDLE.
- **Output gating:** chan_en and ring_bit are nonzero only in SETTLE and COUNT.
- **Counter:** saturates at 2^COUNT_W-1. Any edge detected at saturation sets res_ovf. Counter and ovf are cleared on entry to SETTLE.
- **abort:** has priority over every transition. Next cycle the block is in IDLE, with chan_en, ring_bit and res_valid all 0. A pending result is discarded.
- **start together with abort in IDLE:** abort wins; start is ignored.

## Timing
- **Reset values:** every output is 0 (chan_en, ring_bit, busy, res_valid, res_count, res_chan, res_bit, res_ovf). The state is IDLE.
- **Reset mid-measurement:** same result, asynchronously; no result is emitted.
- **Start to enable:** start sampled high at edge N gives busy, chan_en and ring_bit high from after edge N. These signals are registered outputs.
- **Counting gate:** edges whose detection lands in a COUNT cycle are counted. The detector runs during SETTLE, so synchroniser latency never loses the first window edge.
- **Single-bit latency:** res_valid rises at start + 1 + SETTLE_CYC + window cycles.
- **Sweep restart:** SETTLE for the next bit begins the cycle after the res_valid & res_ready handshake. With res_ready tied high, each REPORT lasts exactly 1 cycle.
- **REPORT hold:** res_valid never drops without handshake or abort.

## Test plan
- **Reset:** assert rst_n low mid-COUNT, asynchronously between clock edges -> all outputs 0 immediately, IDLE after release, no res_valid.
- **Single measurement:** ring_in[2] is a free-running square wave with period 4 clocks. Set chan_sel=2, bit_sel=5, window=100, sweep=0 -> chan_en=4'b0100, ring_bit bit 5 only; res_valid after 109 cycles (SETTLE_CYC=8) with res_count=25, res_chan=2, res_bit=5, res_ovf=0.
- **Sweep with backpressure:** WIDTH=8, bit_sel=5, sweep=1, res_ready low for 10 cycles on each result -> exactly 3 results (bits 5, 6, 7), each held stable while stalled; busy low after the third handshake.
- **Saturation:** COUNT_W=4, window=200, ring period 4 -> res_count=15, res_ovf=1.
- **Edge cases:**
  - window=0 -> res_count=0, res_valid at start+1+SETTLE_CYC.
  - bit_sel=WIDTH+3 -> res_bit=WIDTH-1.
  - chan_sel out of range -> clamped to CHANNELS-1.
- **Abort and ignored start:**
  - abort during COUNT -> IDLE next cycle, no result.
  - abort during REPORT -> res_valid drops.
  - start pulsed while busy -> no change to the latched configuration.

Source files
------------

// File: rtl/instrumented_adder_meter.sv
// Measurement sequencer for the instrumented adders: picks a channel and a ring bit,
// settles, counts ring rising edges over a clock window, optionally sweeping all bits.
module instrumented_adder_meter #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int COUNT_W    = 24,
  parameter int WINDOW_W   = 16,
  parameter int SETTLE_CYC = 8,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BW = $clog2(WIDTH)
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                sweep,
  input  logic [CW-1:0]       chan_sel,
  input  logic [BW-1:0]       bit_sel,
  input  logic [WINDOW_W-1:0] window,
  input  logic [CHANNELS-1:0] ring_in,
  output logic [CHANNELS-1:0] chan_en,
  output logic [WIDTH-1:0]    ring_bit,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [COUNT_W-1:0]  res_count,
  output logic [CW-1:0]       res_chan,
  output logic [BW-1:0]       res_bit,
  output logic                res_ovf
);

  localparam int TW = (WINDOW_W > 8) ? WINDOW_W : 8;
  localparam logic [TW-1:0]      SETTLE_TMR = TW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0]      BIT_MAX    = BW'(WIDTH - 1);
  localparam logic [CW-1:0]      CHAN_MAX   = CW'(CHANNELS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, REPORT} state_t;

  state_t                state_r, state_s;
  logic [CW-1:0]         chan_s;
  logic [BW-1:0]         bit_s;
  logic                  sweep_r, sweep_s;
  logic [WINDOW_W-1:0]   window_r, window_s;
  logic [TW-1:0]         tmr_r, tmr_s;
  logic                  clr_s;
  logic [CHANNELS-1:0]   sync1_r, sync2_r, hist_r;
  logic                  edge_s;
  logic [CW-1:0]         chan_clamp_s;
  logic [BW-1:0]         bit_clamp_s;

  assign chan_clamp_s = (32'(chan_sel) >= CHANNELS) ? CHAN_MAX : chan_sel;
  assign bit_clamp_s  = (32'(bit_sel) >= WIDTH) ? BIT_MAX : bit_sel;
  assign edge_s       = sync2_r[res_chan] & ~hist_r[res_chan];

  // Next-state, configuration latch and settle/window timer.
  always_comb begin
    state_s  = state_r;
    chan_s   = res_chan;
    bit_s    = res_bit;
    sweep_s  = sweep_r;
    window_s = window_r;
    tmr_s    = tmr_r;
    clr_s    = 1'b0;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s  = SETTLE;
            chan_s   = chan_clamp_s;
            bit_s    = bit_clamp_s;
            sweep_s  = sweep;
            window_s = window;
            tmr_s    = SETTLE_TMR;
            clr_s    = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        SETTLE: begin
          if (tmr_r != TW'(0)) begin
            tmr_s = tmr_r - TW'(1);
          end else if (window_r == WINDOW_W'(0)) begin
            state_s = REPORT;
          end else begin
            state_s = COUNT;
            tmr_s   = TW'(window_r) - TW'(1);
          end
        end
        COUNT: begin
          if (tmr_r != TW'(0)) begin
            tmr_s = tmr_r - TW'(1);
          end else begin
            state_s = REPORT;
          end
        end
        REPORT: begin
          if (!res_ready) begin
            state_s = REPORT;
          end else if (sweep_r && (res_bit < BIT_MAX)) begin
            state_s = SETTLE;
            bit_s   = res_bit + BW'(1);
            tmr_s   = SETTLE_TMR;
            clr_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, configuration and registered enables/status.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      res_chan  <= CW'(0);
      res_bit   <= BW'(0);
      sweep_r   <= 1'b0;
      window_r  <= WINDOW_W'(0);
      tmr_r     <= TW'(0);
      busy      <= 1'b0;
      res_valid <= 1'b0;
      chan_en   <= CHANNELS'(0);
      ring_bit  <= WIDTH'(0);
    end else begin
      state_r   <= state_s;
      res_chan  <= chan_s;
      res_bit   <= bit_s;
      sweep_r   <= sweep_s;
      window_r  <= window_s;
      tmr_r     <= tmr_s;
      busy      <= (state_s != IDLE);
      res_valid <= (state_s == REPORT);
      if ((state_s == SETTLE) || (state_s == COUNT)) begin
        chan_en  <= CHANNELS'(1'b1) << chan_s;
        ring_bit <= WIDTH'(1'b1) << bit_s;
      end else begin
        chan_en  <= CHANNELS'(0);
        ring_bit <= WIDTH'(0);
      end
    end
  end

  // Ring tap synchroniser and edge history; runs continuously so no edge is lost.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= CHANNELS'(0);
      sync2_r <= CHANNELS'(0);
      hist_r  <= CHANNELS'(0);
    end else begin
      sync1_r <= ring_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Saturating edge counter, gated to COUNT cycles.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= COUNT_W'(0);
      res_ovf   <= 1'b0;
    end else if (clr_s) begin
      res_count <= COUNT_W'(0);
      res_ovf   <= 1'b0;
    end else if ((state_r == COUNT) && edge_s) begin
      if (res_count == COUNT_MAX) begin
        res_ovf <= 1'b1;
      end else begin
        res_count <= res_count + COUNT_W'(1);
      end
    end else begin
      res_count <= res_count;
    end
  end

endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Directed bench: three meter configurations (default, 8-bit sweep/saturation, non-power-of-2 clamp).
module tb_instrumented_adder_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] ph = 4'd0;
  logic [3:0] ring;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Free-running ring taps: ch0 period 8, ch1 period 2, ch2 period 4, ch3 period 16.
  always @(negedge clk) ph = ph + 4'd1;
  assign ring = {ph[3], ph[1], ph[0], ph[2]};

  // DUT A: default parameters
  logic a_start = 1'b0, a_abort = 1'b0, a_sweep = 1'b0, a_res_ready = 1'b0;
  logic [1:0] a_chan_sel = 2'd0;
  logic [4:0] a_bit_sel = 5'd0;
  logic [15:0] a_window = 16'd0;
  logic [3:0] a_chan_en;
  logic [31:0] a_ring_bit;
  logic a_busy, a_res_valid, a_res_ovf;
  logic [23:0] a_res_count;
  logic [1:0] a_res_chan;
  logic [4:0] a_res_bit;

  instrumented_adder_meter u_a (
    .wb_clk_i(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .sweep(a_sweep),
    .chan_sel(a_chan_sel), .bit_sel(a_bit_sel), .window(a_window), .ring_in(ring),
    .chan_en(a_chan_en), .ring_bit(a_ring_bit), .busy(a_busy), .res_valid(a_res_valid),
    .res_ready(a_res_ready), .res_count(a_res_count), .res_chan(a_res_chan),
    .res_bit(a_res_bit), .res_ovf(a_res_ovf));

  // DUT B: 8-bit adder, 4-bit counter
  logic b_start = 1'b0, b_abort = 1'b0, b_sweep = 1'b0, b_res_ready = 1'b0;
  logic [1:0] b_chan_sel = 2'd0;
  logic [2:0] b_bit_sel = 3'd0;
  logic [15:0] b_window = 16'd0;
  logic [3:0] b_chan_en;
  logic [7:0] b_ring_bit;
  logic b_busy, b_res_valid, b_res_ovf;
  logic [3:0] b_res_count;
  logic [1:0] b_res_chan;
  logic [2:0] b_res_bit;

  instrumented_adder_meter #(.WIDTH(8), .CHANNELS(4), .COUNT_W(4), .WINDOW_W(16), .SETTLE_CYC(8)) u_b (
    .wb_clk_i(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .sweep(b_sweep),
    .chan_sel(b_chan_sel), .bit_sel(b_bit_sel), .window(b_window), .ring_in(ring),
    .chan_en(b_chan_en), .ring_bit(b_ring_bit), .busy(b_busy), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_count(b_res_count), .res_chan(b_res_chan),
    .res_bit(b_res_bit), .res_ovf(b_res_ovf));

  // DUT C: 12-bit adder, 3 channels, short settle
  logic c_start = 1'b0, c_abort = 1'b0, c_sweep = 1'b0, c_res_ready = 1'b0;
  logic [1:0] c_chan_sel = 2'd0;
  logic [3:0] c_bit_sel = 4'd0;
  logic [15:0] c_window = 16'd0;
  logic [2:0] c_chan_en;
  logic [11:0] c_ring_bit;
  logic c_busy, c_res_valid, c_res_ovf;
  logic [7:0] c_res_count;
  logic [1:0] c_res_chan;
  logic [3:0] c_res_bit;

  instrumented_adder_meter #(.WIDTH(12), .CHANNELS(3), .COUNT_W(8), .WINDOW_W(16), .SETTLE_CYC(3)) u_c (
    .wb_clk_i(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .sweep(c_sweep),
    .chan_sel(c_chan_sel), .bit_sel(c_bit_sel), .window(c_window), .ring_in(ring[2:0]),
    .chan_en(c_chan_en), .ring_bit(c_ring_bit), .busy(c_busy), .res_valid(c_res_valid),
    .res_ready(c_res_ready), .res_count(c_res_count), .res_chan(c_res_chan),
    .res_bit(c_res_bit), .res_ovf(c_res_ovf));

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({a_chan_en, a_ring_bit, a_busy, a_res_valid, a_res_count, a_res_chan, a_res_bit, a_res_ovf} !== 68'd0) begin
      n_err++;
      $display("FAIL reset_a: outputs=%h required all zero", {a_chan_en, a_ring_bit, a_busy, a_res_valid, a_res_count, a_res_chan, a_res_bit, a_res_ovf});
    end
    n_vec++;
    if ({b_busy, b_res_valid, b_chan_en, c_busy, c_res_valid, c_chan_en} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_bc: busy/valid/en=%b required all zero", {b_busy, b_res_valid, b_chan_en, c_busy, c_res_valid, c_chan_en});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({a_busy, a_res_valid, b_busy, c_busy} !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release: busy/valid=%b required 0000", {a_busy, a_res_valid, b_busy, c_busy});
    end
  endtask

  task automatic test_single();
    int k;
    logic seen;
    @(posedge clk); #1;
    a_chan_sel = 2'd2; a_bit_sel = 5'd5; a_window = 16'd100; a_sweep = 1'b0; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_chan_sel = 2'd0; a_bit_sel = 5'd1; a_window = 16'd3; a_sweep = 1'b1;
    n_vec++;
    if (a_busy !== 1'b1 || a_chan_en !== 4'b0100 || a_ring_bit !== 32'h0000_0020) begin
      n_err++;
      $display("FAIL single_enable: busy=%b chan_en=%b ring_bit=%h required 1 0100 00000020", a_busy, a_chan_en, a_ring_bit);
    end
    k = 0; seen = 1'b0;
    while (!seen && k < 300) begin
      a_start = (k == 20);
      @(posedge clk); #1;
      k++;
      if (a_res_valid === 1'b1) seen = 1'b1;
    end
    a_start = 1'b0;
    n_vec++;
    if (k !== 108) begin
      n_err++;
      $display("FAIL single_latency: res_valid after %0d cycles required 108", k);
    end
    n_vec++;
    if (a_res_count !== 24'd25 || a_res_chan !== 2'd2 || a_res_bit !== 5'd5 || a_res_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: count=%0d chan=%0d bit=%0d ovf=%b required 25 2 5 0", a_res_count, a_res_chan, a_res_bit, a_res_ovf);
    end
    n_vec++;
    if (a_chan_en !== 4'd0 || a_ring_bit !== 32'd0) begin
      n_err++;
      $display("FAIL single_report_gating: chan_en=%b ring_bit=%h required 0 0", a_chan_en, a_ring_bit);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (a_res_valid !== 1'b1 || a_res_count !== 24'd25) begin
      n_err++;
      $display("FAIL single_hold: valid=%b count=%0d required 1 25", a_res_valid, a_res_count);
    end
    a_res_ready = 1'b1;
    @(posedge clk); #1;
    a_res_ready = 1'b0;
    n_vec++;
    if (a_res_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_handshake: valid=%b busy=%b required 0 0 (no sweep)", a_res_valid, a_busy);
    end
  endtask

  task automatic test_window_zero();
    int k;
    @(posedge clk); #1;
    a_chan_sel = 2'd0; a_bit_sel = 5'd3; a_window = 16'd0; a_sweep = 1'b0; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    k = 0;
    while (a_res_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k !== 8 || a_res_count !== 24'd0 || a_res_bit !== 5'd3) begin
      n_err++;
      $display("FAIL window_zero: latency=%0d count=%0d bit=%0d required 8 0 3", k, a_res_count, a_res_bit);
    end
    a_res_ready = 1'b1;
    @(posedge clk); #1;
    a_res_ready = 1'b0;
  endtask

  task automatic test_abort();
    int k;
    logic seen;
    @(posedge clk); #1;
    a_chan_sel = 2'd2; a_bit_sel = 5'd7; a_window = 16'd100; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    n_vec++;
    if (a_busy !== 1'b0 || a_chan_en !== 4'd0 || a_ring_bit !== 32'd0 || a_res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_count: busy=%b chan_en=%b ring_bit=%h valid=%b required 0 0 0 0", a_busy, a_chan_en, a_ring_bit, a_res_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (a_res_valid === 1'b1 || a_busy === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_result: activity seen=%b required 0", seen);
    end
    // start and abort together in IDLE
    a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_abort = 1'b0;
    n_vec++;
    if (a_busy !== 1'b0 || a_chan_en !== 4'd0) begin
      n_err++;
      $display("FAIL abort_start_idle: busy=%b chan_en=%b required 0 0", a_busy, a_chan_en);
    end
    a_window = 16'd4; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    k = 0;
    while (a_res_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k !== 12) begin
      n_err++;
      $display("FAIL abort_report_setup: latency=%0d required 12", k);
    end
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    n_vec++;
    if (a_res_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_report: valid=%b busy=%b required 0 0", a_res_valid, a_busy);
    end
  endtask

  task automatic test_sweep();
    int k;
    logic stable;
    logic [7:0] exp_rb;
    @(posedge clk); #1;
    b_chan_sel = 2'd1; b_bit_sel = 3'd5; b_window = 16'd20; b_sweep = 1'b1; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      k = 0;
      while (b_res_valid !== 1'b1 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      n_vec++;
      if (b_res_bit !== 3'(5 + r) || b_res_count !== 4'd10 || b_res_chan !== 2'd1 || k !== 28) begin
        n_err++;
        $display("FAIL sweep_result%0d: bit=%0d count=%0d chan=%0d latency=%0d required %0d 10 1 28", r, b_res_bit, b_res_count, b_res_chan, k, 5 + r);
      end
      stable = 1'b1;
      for (int s = 0; s < 10; s++) begin
        @(posedge clk); #1;
        if (b_res_valid !== 1'b1 || b_res_bit !== 3'(5 + r) || b_res_count !== 4'd10) stable = 1'b0;
      end
      n_vec++;
      if (stable !== 1'b1) begin
        n_err++;
        $display("FAIL sweep_stall%0d: stable=%b required 1", r, stable);
      end
      b_res_ready = 1'b1;
      @(posedge clk); #1;
      b_res_ready = 1'b0;
      exp_rb = (r < 2) ? (8'd1 << (6 + r)) : 8'd0;
      n_vec++;
      if (b_busy !== (r < 2) || b_ring_bit !== exp_rb || b_res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_handshake%0d: busy=%b ring_bit=%b valid=%b required %b %b 0", r, b_busy, b_ring_bit, b_res_valid, (r < 2), exp_rb);
      end
    end
    stable = 1'b1;
    for (int s = 0; s < 40; s++) begin
      @(posedge clk); #1;
      if (b_res_valid === 1'b1 || b_busy === 1'b1) stable = 1'b0;
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_extra_result: quiet=%b required 1", stable);
    end
  endtask

  task automatic test_saturation();
    int k;
    @(posedge clk); #1;
    b_chan_sel = 2'd2; b_bit_sel = 3'd0; b_window = 16'd200; b_sweep = 1'b0; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    k = 0;
    while (b_res_valid !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k !== 208 || b_res_count !== 4'd15 || b_res_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL saturation: latency=%0d count=%0d ovf=%b required 208 15 1", k, b_res_count, b_res_ovf);
    end
    b_res_ready = 1'b1;
    @(posedge clk); #1;
    b_res_ready = 1'b0;
  endtask

  task automatic test_clamp();
    int k;
    @(posedge clk); #1;
    c_chan_sel = 2'd3; c_bit_sel = 4'd15; c_window = 16'd16; c_sweep = 1'b0; c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    n_vec++;
    if (c_chan_en !== 3'b100 || c_ring_bit !== 12'h800) begin
      n_err++;
      $display("FAIL clamp_enable: chan_en=%b ring_bit=%h required 100 800", c_chan_en, c_ring_bit);
    end
    k = 0;
    while (c_res_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k !== 19 || c_res_bit !== 4'd11 || c_res_chan !== 2'd2 || c_res_count !== 8'd4) begin
      n_err++;
      $display("FAIL clamp_result: latency=%0d bit=%0d chan=%0d count=%0d required 19 11 2 4", k, c_res_bit, c_res_chan, c_res_count);
    end
    c_res_ready = 1'b1;
    @(posedge clk); #1;
    c_res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(posedge clk); #1;
    a_chan_sel = 2'd2; a_bit_sel = 5'd9; a_window = 16'd100; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_chan_en, a_ring_bit, a_busy, a_res_valid, a_res_count, a_res_chan, a_res_bit, a_res_ovf} !== 68'd0) begin
      n_err++;
      $display("FAIL reset_mid: outputs=%h required all zero", {a_chan_en, a_ring_bit, a_busy, a_res_valid, a_res_count, a_res_chan, a_res_bit, a_res_ovf});
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (a_res_valid === 1'b1 || a_busy === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_result: activity=%b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_window_zero();
    test_abort();
    test_sweep();
    test_saturation();
    test_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
